segment_monitor: RTL and testbench
==================================

Name: segment_monitor

Overview:
- Reads a 7-segment drive bus and recovers the hex digit it shows: the reading end of the segment bus driven by the button counter.
- Used for on-board loopback self-check and as a scoreboard front-end in simulation.
- Filters glitches with a stability window and reports each new stable digit through a valid/ready handshake.
- Flags illegal patterns and overruns.

Parameters:
- STABLE_TIME, 250_000, cycles a pattern must hold unchanged before it is decoded (10 ms @ 25 MHz). Minimum 1. Simulation uses 4.
- ACTIVE_LOW, 1, 1 = a segment is lit when its bit is 0 (Go Board); 0 = lit when 1.

Ports:
- i_Clk  input  1  system clock, 25 MHz.
- i_Reset  input  1  synchronous, active-high reset.
- i_Segments  input  7  segment bus {G,F,E,D,C,B,A}, bit 0 = A; asynchronous to i_Clk.
- o_Digit  output  4  decoded hex value; stable while o_Valid = 1.
- o_Valid  output  1  report pending.
- i_Ready  input  1  consumer accepts the report when o_Valid & i_Ready.
- o_Invalid  output  1  one-cycle pulse when a stable, non-blank pattern is not a legal glyph.
- o_Overrun  output  1  one-cycle pulse when a pending report is overwritten.
- o_Report_Count  output  8  number of accepted reports, wraps at 255 -> 0.

Behaviour:
- Reset (i_Reset = 1 at a clock edge): o_Digit = 0, o_Valid = 0, o_Invalid = 0, o_Overrun = 0, o_Report_Count = 0.
  - Synchronizer flops, candidate register and last-reported register are cleared. The candidate is cleared to blank.
  - The stability counter is set to 0 and the FSM goes to IDLE.
  - Reset has priority over every other event; a pending report is discarded.
- Input: 2-flop synchronizer. Polarity is then normalized to lit = 1 (XOR with {7{ACTIVE_LOW}}).
- Candidate tracking: the normalized sample is compared each cycle with the candidate register.
  - Different: candidate <= sample, counter <= 0, FSM -> SETTLE.
  - Equal in SETTLE: counter increments; at STABLE_TIME-1 the FSM evaluates (below) and goes to STABLE.
  - Counter width is $clog2(STABLE_TIME+1). The counter does not run in IDLE or STABLE.
- FSM states:
  - IDLE: after reset; waits for the first change from blank.
  - SETTLE: counting the stability window.
  - STABLE: candidate decoded; waits for the next change.
- Evaluation at the end of the window:
  - Blank (0x00): no event. o_Digit and the last-reported value are kept.
  - Legal glyph, value differs from the last-reported value, or no report yet since reset: load o_Digit, assert o_Valid, update last-reported.
  - Legal glyph, same value as the last report: no event.
  - Illegal pattern: o_Invalid pulses for 1 cycle; no report.
- Latency: an input change held constant raises o_Valid exactly STABLE_TIME+2 cycles after the first edge at which the new value is sampled.
- Legal glyphs (lit = 1, {G..A}), 0..F:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07
  - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71
- Handshake:
  - o_Valid stays high and o_Digit stays constant until a cycle with o_Valid & i_Ready.
  - Acceptance: the next cycle has o_Valid = 0 and o_Report_Count + 1.
  - i_Ready may be held high permanently; each report then lasts exactly 1 cycle.
- Overrun: a new report evaluates in the same cycle as an unaccepted pending report. o_Digit takes the new value, o_Valid stays 1, o_Overrun pulses, and the count is not incremented.
- Simultaneous acceptance and new evaluation: the old report counts as accepted (count + 1) and the new report is loaded with o_Valid = 1. No overrun.
- A glitch shorter than STABLE_TIME restarts the window. If the glitch is followed by the original pattern, the original value is re-evaluated and suppressed as a duplicate.

Optional Feature:
- Macro: SEGMENT_MONITOR_ALT_GLYPHS_EN.
- Defined: alternate shapes are also legal: 7 = 27 (F lit) and 9 = 67 (D unlit).
- Undefined: 27 and 67 are illegal and produce o_Invalid. No other change in timing or ports.

Test Plan (STABLE_TIME = 4, ACTIVE_LOW = 1, i_Ready = 1 unless stated):
- Reset, then drive ~5B (0x24) constant -> o_Valid for 1 cycle at sample edge + 6, o_Digit = 2, o_Report_Count = 1.
- Drive 0x24, toggle to 0x00 for 2 cycles, back to 0x24 -> exactly one report of 2; the glitch produces neither o_Invalid nor a report.
- Pattern lit = 0x01 held for 6 cycles -> single o_Invalid pulse, o_Valid stays 0. Pattern 27 -> o_Invalid without the macro; report of 7 with it.
- i_Ready = 0; drive lit 06 then lit 4F, each held for 8 cycles -> first o_Digit = 1, then o_Digit = 3 with an o_Overrun pulse. Raise i_Ready -> count increments by exactly 1.
- Hold lit 3F, blank for 8 cycles, lit 3F again -> a single report of 0 only.
- Assert i_Reset while o_Valid = 1 -> next cycle all outputs 0. The same digit afterwards is reported again.

Source files
------------

// File: rtl/segment_monitor.sv
// rtl/segment_monitor.sv - 7-segment bus reader with glitch filter, valid/ready digit reports
// Optional: define SEGMENT_MONITOR_ALT_GLYPHS_EN to also accept alternate 7 (0x27) and 9 (0x67) shapes.

module segment_monitor #(
    parameter int STABLE_TIME = 250_000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [6:0] i_Segments,
    output logic [3:0] o_Digit,
    output logic       o_Valid,
    input  logic       i_Ready,
    output logic       o_Invalid,
    output logic       o_Overrun,
    output logic [7:0] o_Report_Count
);
    localparam int            CW         = $clog2(STABLE_TIME + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TIME - 1);
    localparam logic [6:0]    IDLE_LEVEL = {7{ACTIVE_LOW}};

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_STABLE} state_t;

    // Returns {legal, value}; value is meaningless when legal = 0.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   decode = {1'b1, 4'h0};
            7'h06:   decode = {1'b1, 4'h1};
            7'h5B:   decode = {1'b1, 4'h2};
            7'h4F:   decode = {1'b1, 4'h3};
            7'h66:   decode = {1'b1, 4'h4};
            7'h6D:   decode = {1'b1, 4'h5};
            7'h7D:   decode = {1'b1, 4'h6};
            7'h07:   decode = {1'b1, 4'h7};
            7'h7F:   decode = {1'b1, 4'h8};
            7'h6F:   decode = {1'b1, 4'h9};
            7'h77:   decode = {1'b1, 4'hA};
            7'h7C:   decode = {1'b1, 4'hB};
            7'h39:   decode = {1'b1, 4'hC};
            7'h5E:   decode = {1'b1, 4'hD};
            7'h79:   decode = {1'b1, 4'hE};
            7'h71:   decode = {1'b1, 4'hF};
`ifdef SEGMENT_MONITOR_ALT_GLYPHS_EN
            7'h27:   decode = {1'b1, 4'h7};
            7'h67:   decode = {1'b1, 4'h9};
`else
`endif
            default: decode = 5'b0_0000;
        endcase
    endfunction

    logic [6:0]    sync1_q, sync2_q;
    logic [6:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [3:0]    digit_q, digit_d;
    logic          valid_q, valid_d;
    logic          invalid_q, invalid_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    count_q, count_d;
    logic [3:0]    last_q, last_d;
    logic          has_last_q, has_last_d;

    logic [6:0]    sample;
    logic [4:0]    glyph;
    logic          eval;
    logic          accept;

    assign sample = sync2_q ^ {7{ACTIVE_LOW}};
    assign glyph  = decode(cand_q);
    assign accept = valid_q & i_Ready;

    always_comb begin
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        digit_d    = digit_q;
        valid_d    = valid_q;
        invalid_d  = 1'b0;
        overrun_d  = 1'b0;
        count_d    = count_q;
        last_d     = last_q;
        has_last_d = has_last_q;
        eval       = 1'b0;

        if (sample != cand_q) begin
            cand_d  = sample;
            cnt_d   = '0;
            state_d = S_SETTLE;
        end else if (state_q == S_SETTLE) begin
            if (cnt_q == CNT_LAST) begin
                eval    = 1'b1;
                state_d = S_STABLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (accept) begin
            valid_d = 1'b0;
            count_d = count_q + 8'd1;
        end

        // Blank patterns are silent; duplicates of the last report are suppressed.
        if (eval && (cand_q != 7'h00)) begin
            if (!glyph[4]) begin
                invalid_d = 1'b1;
            end else if (!has_last_q || (glyph[3:0] != last_q)) begin
                digit_d    = glyph[3:0];
                valid_d    = 1'b1;
                last_d     = glyph[3:0];
                has_last_d = 1'b1;
                overrun_d  = valid_q & ~i_Ready;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            // Synchronizer idles at the unlit level so reset never fakes a lit pattern.
            sync1_q    <= IDLE_LEVEL;
            sync2_q    <= IDLE_LEVEL;
            cand_q     <= 7'h00;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
            digit_q    <= 4'h0;
            valid_q    <= 1'b0;
            invalid_q  <= 1'b0;
            overrun_q  <= 1'b0;
            count_q    <= 8'h00;
            last_q     <= 4'h0;
            has_last_q <= 1'b0;
        end else begin
            sync1_q    <= i_Segments;
            sync2_q    <= sync1_q;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            digit_q    <= digit_d;
            valid_q    <= valid_d;
            invalid_q  <= invalid_d;
            overrun_q  <= overrun_d;
            count_q    <= count_d;
            last_q     <= last_d;
            has_last_q <= has_last_d;
        end
    end

    assign o_Digit        = digit_q;
    assign o_Valid        = valid_q;
    assign o_Invalid      = invalid_q;
    assign o_Overrun      = overrun_q;
    assign o_Report_Count = count_q;

endmodule

// File: tb/tb_segment_monitor.sv
// tb/tb_segment_monitor.sv - randomized and directed bench for segment_monitor with a history-based reference model

module tb_segment_monitor;
    localparam int ST = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic       ready;
    logic [3:0] o_digit;
    logic       o_valid;
    logic       o_invalid;
    logic       o_overrun;
    logic [7:0] o_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    segment_monitor #(.STABLE_TIME(ST), .ACTIVE_LOW(1'b1)) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_Segments     (seg),
        .o_Digit        (o_digit),
        .o_Valid        (o_valid),
        .i_Ready        (ready),
        .o_Invalid      (o_invalid),
        .o_Overrun      (o_overrun),
        .o_Report_Count (o_count)
    );

    // Reference model: lit patterns seen since reset, and the expected outputs.
    logic [6:0] hq[$];
    logic [3:0] m_digit;
    logic       m_valid, m_inv, m_ov;
    logic [7:0] m_count;
    int         m_last;
    bit         m_has;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [6:0] hist(input int i);
        if (i < 0 || i >= hq.size()) return 7'h00;
        return hq[i];
    endfunction

    function automatic int glyph_of(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (glyph_tab[i] == p) return i;
`ifdef SEGMENT_MONITOR_ALT_GLYPHS_EN
        if (p == 7'h27) return 7;
        if (p == 7'h67) return 9;
`endif
        return -1;
    endfunction

    // One clock: drive lit pattern (converted to active-low), ready and reset; advance the model.
    task automatic tick(input logic [6:0] lit, input logic rdy, input logic r);
        int         t;
        logic [6:0] p;
        bit         ev;
        int         g;
        logic       old_valid;
        @(negedge clk);
        seg   = lit ^ 7'h7F;
        ready = rdy;
        rst   = r;
        @(posedge clk);
        if (r) begin
            hq.delete();
            m_digit = 4'h0; m_valid = 1'b0; m_inv = 1'b0; m_ov = 1'b0;
            m_count = 8'h00; m_last = 0; m_has = 1'b0;
        end else begin
            hq.push_back(lit);
            t  = hq.size() - 1;
            p  = hist(t - 2);
            // A decode happens once a run of ST+1 identical samples has just completed.
            ev = (hist(t - 3 - ST) != p);
            for (int k = 0; k <= ST; k++)
                if (hist(t - 2 - k) != p) ev = 1'b0;
            m_inv = 1'b0;
            m_ov  = 1'b0;
            old_valid = m_valid;
            if (m_valid && rdy) begin
                m_valid = 1'b0;
                m_count = m_count + 8'd1;
            end
            if (ev && p != 7'h00) begin
                g = glyph_of(p);
                if (g < 0) m_inv = 1'b1;
                else if (!m_has || g != m_last) begin
                    m_ov    = old_valid && !rdy;
                    m_digit = 4'(g);
                    m_valid = 1'b1;
                    m_last  = g;
                    m_has   = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset;
        tick(7'h00, 1'b1, 1'b1);
        tick(7'h00, 1'b1, 1'b1);
        total += 5;
        if (o_digit !== 4'h0)   begin bad++; $display("FAIL reset_digit got=%h exp=0", o_digit); end
        if (o_valid !== 1'b0)   begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        if (o_invalid !== 1'b0) begin bad++; $display("FAIL reset_invalid got=%b exp=0", o_invalid); end
        if (o_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", o_overrun); end
        if (o_count !== 8'h00)  begin bad++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    endtask

    task automatic test_latency;
        int first = -1;
        int nvalid = 0;
        logic [3:0] dig = 4'hx;
        tick(7'h00, 1'b1, 1'b1);
        for (int k = 0; k < 12; k++) begin
            tick(7'h5B, 1'b1, 1'b0);
            if (o_valid === 1'b1) begin
                nvalid++;
                if (first < 0) begin first = k; dig = o_digit; end
            end
        end
        total += 4;
        if (first != ST + 2) begin bad++; $display("FAIL latency got=%0d exp=%0d", first, ST + 2); end
        if (dig !== 4'h2)    begin bad++; $display("FAIL latency_digit got=%h exp=2", dig); end
        if (nvalid != 1)     begin bad++; $display("FAIL latency_valid_cycles got=%0d exp=1", nvalid); end
        if (o_count !== 8'd1) begin bad++; $display("FAIL latency_count got=%0d exp=1", o_count); end
    endtask

    task automatic test_glitch;
        int nrep = 0;
        int ninv = 0;
        tick(7'h00, 1'b1, 1'b1);
        for (int k = 0; k < 24; k++) begin
            tick((k == 10 || k == 11) ? 7'h7F : 7'h5B, 1'b1, 1'b0);
            if (o_valid === 1'b1) nrep++;
            if (o_invalid === 1'b1) ninv++;
        end
        total += 4;
        if (nrep != 1)        begin bad++; $display("FAIL glitch_reports got=%0d exp=1", nrep); end
        if (ninv != 0)        begin bad++; $display("FAIL glitch_invalid got=%0d exp=0", ninv); end
        if (o_digit !== 4'h2) begin bad++; $display("FAIL glitch_digit got=%h exp=2", o_digit); end
        if (o_count !== 8'd1) begin bad++; $display("FAIL glitch_count got=%0d exp=1", o_count); end
    endtask

    task automatic test_invalid;
        int ninv = 0;
        int nrep = 0;
        tick(7'h00, 1'b1, 1'b1);
        for (int k = 0; k < 12; k++) begin
            tick(k < 6 ? 7'h01 : 7'h00, 1'b1, 1'b0);
            if (o_invalid === 1'b1) ninv++;
            if (o_valid === 1'b1) nrep++;
        end
        total += 2;
        if (ninv != 1) begin bad++; $display("FAIL invalid_pulses got=%0d exp=1", ninv); end
        if (nrep != 0) begin bad++; $display("FAIL invalid_reports got=%0d exp=0", nrep); end
        ninv = 0;
        nrep = 0;
        for (int k = 0; k < 16; k++) begin
            tick(k < 8 ? 7'h27 : 7'h00, 1'b1, 1'b0);
            if (o_invalid === 1'b1) ninv++;
            if (o_valid === 1'b1) nrep++;
        end
        total += 2;
`ifdef SEGMENT_MONITOR_ALT_GLYPHS_EN
        if (ninv != 0 || nrep != 1) begin bad++; $display("FAIL alt7_events got inv=%0d rep=%0d exp inv=0 rep=1", ninv, nrep); end
        if (o_digit !== 4'h7) begin bad++; $display("FAIL alt7_digit got=%h exp=7", o_digit); end
`else
        if (ninv != 1 || nrep != 0) begin bad++; $display("FAIL alt7_events got inv=%0d rep=%0d exp inv=1 rep=0", ninv, nrep); end
        if (o_digit !== 4'h0) begin bad++; $display("FAIL alt7_digit got=%h exp=0", o_digit); end
`endif
    endtask

    task automatic test_overrun;
        int nov = 0;
        tick(7'h00, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick(7'h06, 1'b0, 1'b0);
            if (o_overrun === 1'b1) nov++;
        end
        total += 2;
        if (o_digit !== 4'h1 || o_valid !== 1'b1) begin bad++; $display("FAIL ovr_first got digit=%h valid=%b exp digit=1 valid=1", o_digit, o_valid); end
        if (nov != 0) begin bad++; $display("FAIL ovr_early got=%0d exp=0", nov); end
        for (int k = 0; k < 8; k++) begin
            tick(7'h4F, 1'b0, 1'b0);
            if (o_overrun === 1'b1) nov++;
        end
        total += 3;
        if (o_digit !== 4'h3 || o_valid !== 1'b1) begin bad++; $display("FAIL ovr_second got digit=%h valid=%b exp digit=3 valid=1", o_digit, o_valid); end
        if (nov != 1)         begin bad++; $display("FAIL ovr_pulses got=%0d exp=1", nov); end
        if (o_count !== 8'd0) begin bad++; $display("FAIL ovr_count_hold got=%0d exp=0", o_count); end
        tick(7'h4F, 1'b1, 1'b0);
        total += 1;
        if (o_count !== 8'd1 || o_valid !== 1'b0) begin bad++; $display("FAIL ovr_accept got count=%0d valid=%b exp count=1 valid=0", o_count, o_valid); end
        for (int k = 0; k < 3; k++) tick(7'h4F, 1'b1, 1'b0);
        total += 1;
        if (o_count !== 8'd1) begin bad++; $display("FAIL ovr_count_after got=%0d exp=1", o_count); end
    endtask

    task automatic test_blank;
        int nrep = 0;
        tick(7'h00, 1'b1, 1'b1);
        for (int k = 0; k < 26; k++) begin
            tick((k >= 8 && k < 16) ? 7'h00 : 7'h3F, 1'b1, 1'b0);
            if (o_valid === 1'b1) nrep++;
        end
        total += 3;
        if (nrep != 1)        begin bad++; $display("FAIL blank_reports got=%0d exp=1", nrep); end
        if (o_digit !== 4'h0) begin bad++; $display("FAIL blank_digit got=%h exp=0", o_digit); end
        if (o_count !== 8'd1) begin bad++; $display("FAIL blank_count got=%0d exp=1", o_count); end
    endtask

    task automatic test_reset_pending;
        int nrep = 0;
        tick(7'h00, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) tick(7'h6D, 1'b0, 1'b0);
        total += 1;
        if (o_valid !== 1'b1 || o_digit !== 4'h5) begin bad++; $display("FAIL rstp_pending got valid=%b digit=%h exp valid=1 digit=5", o_valid, o_digit); end
        tick(7'h6D, 1'b0, 1'b1);
        total += 1;
        if ({o_digit, o_valid, o_invalid, o_overrun, o_count} !== 15'h0) begin
            bad++; $display("FAIL rstp_clear got digit=%h valid=%b inv=%b ovr=%b count=%0d exp all 0", o_digit, o_valid, o_invalid, o_overrun, o_count);
        end
        for (int k = 0; k < 10; k++) begin
            tick(7'h6D, 1'b1, 1'b0);
            if (o_valid === 1'b1) nrep++;
        end
        total += 2;
        if (nrep != 1)        begin bad++; $display("FAIL rstp_rereport got=%0d exp=1", nrep); end
        if (o_count !== 8'd1 || o_digit !== 4'h5) begin bad++; $display("FAIL rstp_after got count=%0d digit=%h exp count=1 digit=5", o_count, o_digit); end
    endtask

    task automatic test_random;
        logic [6:0] pat;
        logic       rdy;
        int         hold;
        int         sel;
        int         cyc = 0;
        tick(7'h00, 1'b1, 1'b1);
        while (cyc < 1500) begin
            sel = $urandom_range(0, 21);
            if (sel < 16)       pat = glyph_tab[sel];
            else if (sel == 16) pat = 7'h00;
            else if (sel == 17) pat = 7'h01;
            else if (sel == 18) pat = 7'h27;
            else if (sel == 19) pat = 7'h67;
            else                pat = 7'($urandom);
            hold = $urandom_range(1, ST + 5);
            for (int k = 0; k < hold; k++) begin
                rdy = ($urandom_range(0, 3) != 0);
                tick(pat, rdy, ($urandom_range(0, 299) == 0));
                cyc++;
                total += 5;
                if (o_valid !== m_valid)     begin bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, o_valid, m_valid); end
                if (o_digit !== m_digit)     begin bad++; $display("FAIL rand_digit cyc=%0d got=%h exp=%h", cyc, o_digit, m_digit); end
                if (o_invalid !== m_inv)     begin bad++; $display("FAIL rand_invalid cyc=%0d got=%b exp=%b", cyc, o_invalid, m_inv); end
                if (o_overrun !== m_ov)      begin bad++; $display("FAIL rand_overrun cyc=%0d got=%b exp=%b", cyc, o_overrun, m_ov); end
                if (o_count !== m_count)     begin bad++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, o_count, m_count); end
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        seg   = 7'h7F;
        ready = 1'b1;
        test_reset();
        test_latency();
        test_glitch();
        test_invalid();
        test_overrun();
        test_blank();
        test_reset_pending();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
